// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared counter encodings and FSM state codes for the branch predictor
package branch_predictor_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational 2-bit saturating increment/decrement
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] nxt
);

    // step toward strong-taken on inc, toward strong-not-taken otherwise, holding at the ends
    always_comb begin
        nxt = inc ? ((cnt == BP_ST)  ? BP_ST  : cnt + 2'd1)
                  : ((cnt == BP_SNT) ? BP_SNT : cnt - 2'd1);
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit counters plus tagged BTB; optional statistics under BP_STATS_EN
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    input  logic        upd_valid_D,
    input  logic [31:0] upd_pc_D,
    input  logic        upd_taken_D,
    input  logic [31:0] upd_target_D,
    input  logic        pred_taken_D,
    input  logic [31:0] pred_target_D,
    output logic        mispredict_D,
    output logic [31:0] redirect_pc_D,
    output logic        ready,
    output logic [31:0] stat_br,
    output logic [31:0] stat_mis
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_tab [DEPTH];
    logic             val_tab [DEPTH];
    logic [TAG_W-1:0] tag_tab [DEPTH];
    logic [31:0]      tgt_tab [DEPTH];

    bp_state_t        state, state_nxt;
    logic [IDX_W-1:0] init_idx, init_idx_nxt;
    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic [1:0]       cnt_nxt;
    logic             hit;

    assign f_idx = pc_F[IDX_W+1:2];
    assign f_tag = pc_F[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc_D[IDX_W+1:2];
    assign u_tag = upd_pc_D[IDX_W+TAG_W+1:IDX_W+2];

    bp_sat_counter u_sat (
        .cnt (cnt_tab[u_idx]),
        .inc (upd_taken_D),
        .nxt (cnt_nxt)
    );

    // state and sweep pointer; reset restarts the initialisation sweep
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= BP_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
        end
    end

    // sweep every entry once, then stay in RUN
    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        if (state == BP_INIT) begin
            init_idx_nxt = init_idx + 1'b1;
            state_nxt    = (init_idx == IDX_W'(DEPTH - 1)) ? BP_RUN : BP_INIT;
        end
    end

    // tables carry no reset so they stay RAM-shaped; INIT clears them, RUN trains them
    always_ff @(posedge clk) begin
        if (state == BP_INIT) begin
            cnt_tab[init_idx] <= BP_WNT;
            val_tab[init_idx] <= 1'b0;
            tag_tab[init_idx] <= '0;
            tgt_tab[init_idx] <= '0;
        end else if (upd_valid_D) begin
            cnt_tab[u_idx] <= cnt_nxt;
            if (upd_taken_D) begin
                val_tab[u_idx] <= 1'b1;
                tag_tab[u_idx] <= u_tag;
                tgt_tab[u_idx] <= upd_target_D;
            end
        end
    end

    // fetch lookup, gated off until the sweep completes
    always_comb begin
        hit           = val_tab[f_idx] & (tag_tab[f_idx] == f_tag);
        pred_taken_F  = (state == BP_RUN) & cnt_tab[f_idx][1] & hit;
        pred_target_F = pred_taken_F ? tgt_tab[f_idx] : pc_F + 32'd4;
        ready         = (state == BP_RUN);
    end

    // D-stage redirect, live in both states
    always_comb begin
        mispredict_D  = upd_valid_D & ((pred_taken_D != upd_taken_D) |
                        (upd_taken_D & (pred_target_D != upd_target_D)));
        redirect_pc_D = upd_taken_D ? upd_target_D : upd_pc_D + 32'd4;
    end

`ifdef BP_STATS_EN
    // resolved-branch and misprediction counts, wrapping at 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (upd_valid_D)  stat_br  <= stat_br + 32'd1;
            if (mispredict_D) stat_mis <= stat_mis + 32'd1;
        end
    end
`else
    assign stat_br  = '0;
    assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc_F = '0;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        upd_valid_D = 1'b0;
    logic [31:0] upd_pc_D = '0;
    logic        upd_taken_D = 1'b0;
    logic [31:0] upd_target_D = '0;
    logic        pred_taken_D = 1'b0;
    logic [31:0] pred_target_D = '0;
    logic        mispredict_D;
    logic [31:0] redirect_pc_D;
    logic        ready;
    logic [31:0] stat_br, stat_mis;

    typedef struct {
        int          k;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] m_br = '0;
    logic [31:0] m_mis = '0;

    branch_predictor dut (
        .clk           (clk),
        .rstn          (rstn),
        .pc_F          (pc_F),
        .pred_taken_F  (pred_taken_F),
        .pred_target_F (pred_target_F),
        .upd_valid_D   (upd_valid_D),
        .upd_pc_D      (upd_pc_D),
        .upd_taken_D   (upd_taken_D),
        .upd_target_D  (upd_target_D),
        .pred_taken_D  (pred_taken_D),
        .pred_target_D (pred_target_D),
        .mispredict_D  (mispredict_D),
        .redirect_pc_D (redirect_pc_D),
        .ready         (ready),
        .stat_br       (stat_br),
        .stat_mis      (stat_mis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sel(input int k);
        case (k)
            0: sel = {31'd0, ready};
            1: sel = {31'd0, pred_taken_F};
            2: sel = pred_target_F;
            3: sel = {31'd0, mispredict_D};
            4: sel = redirect_pc_D;
            5: sel = stat_br;
            default: sel = stat_mis;
        endcase
    endfunction

    function automatic string nm(input int k);
        case (k)
            0: nm = "ready";
            1: nm = "pred_taken_F";
            2: nm = "pred_target_F";
            3: nm = "mispredict_D";
            4: nm = "redirect_pc_D";
            5: nm = "stat_br";
            default: nm = "stat_mis";
        endcase
    endfunction

    // monitor: drain expectations while outputs are stable between edges
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = sel(e.k);
            n_vec++;
            if (act !== e.v) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h at %0t", nm(e.k), act, e.v, $time);
            end
        end
    end

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.k = k;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic ptd,
                       input logic [31:0] ptgtd, input logic e_pt, input logic [31:0] e_ptgt,
                       input logic e_mis, input logic [31:0] e_red, input logic e_rdy);
        pc_F = pc; upd_valid_D = uv; upd_pc_D = upc; upd_taken_D = ut;
        upd_target_D = utgt; pred_taken_D = ptd; pred_target_D = ptgtd;
        push(0, {31'd0, e_rdy});
        push(1, {31'd0, e_pt});
        push(2, e_ptgt);
        push(3, {31'd0, e_mis});
        push(4, e_red);
`ifdef BP_STATS_EN
        push(5, m_br);
        push(6, m_mis);
`else
        push(5, 32'd0);
        push(6, 32'd0);
`endif
        if (rstn) begin
            if (uv) m_br++;
            if (e_mis) m_mis++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        repeat (3) cyc(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 0, 32'h4, 0);
        rstn = 1'b1;
        // INIT: ready low for 64 cycles, updates ignored, redirect still live
        repeat (64) cyc(32'h1000, 1, 32'h1000, 1, 32'hF00, 0, 32'h0, 0, 32'h1004, 1, 32'hF00, 0);
        cyc(32'h1000, 0, 32'h1000, 0, 32'h0, 0, 32'h0, 0, 32'h1004, 0, 32'h1004, 1);
        // train 0x1000 taken; same-cycle lookup sees the old value
        cyc(32'h1000, 1, 32'h1000, 1, 32'hF00, 0, 32'h1004, 0, 32'h1004, 1, 32'hF00, 1);
        cyc(32'h1000, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'hF00, 0, 32'h4, 1);
        cyc(32'h1000, 1, 32'h1000, 1, 32'hF00, 1, 32'hF00, 1, 32'hF00, 0, 32'hF00, 1);
        // alias: same index, different tag
        cyc(32'h2000, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h2004, 0, 32'h4, 1);
        // four not-taken from strong-taken: 11,10,01,00
        cyc(32'h1000, 1, 32'h1000, 0, 32'h0, 1, 32'hF00, 1, 32'hF00, 1, 32'h1004, 1);
        cyc(32'h1000, 1, 32'h1000, 0, 32'h0, 1, 32'hF00, 1, 32'hF00, 1, 32'h1004, 1);
        cyc(32'h1000, 1, 32'h1000, 0, 32'h0, 0, 32'h1004, 0, 32'h1004, 0, 32'h1004, 1);
        cyc(32'h1000, 1, 32'h1000, 0, 32'h0, 0, 32'h1004, 0, 32'h1004, 0, 32'h1004, 1);
        cyc(32'h1000, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h1004, 0, 32'h4, 1);
        // one taken from 00 lands on 01: still not predicted
        cyc(32'h1000, 1, 32'h1000, 1, 32'hF00, 0, 32'h1004, 0, 32'h1004, 1, 32'hF00, 1);
        cyc(32'h1000, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h1004, 0, 32'h4, 1);
        // upper saturation at 0x3004: three taken then one not-taken leaves 10
        cyc(32'h3004, 1, 32'h3004, 1, 32'h5000, 0, 32'h3008, 0, 32'h3008, 1, 32'h5000, 1);
        cyc(32'h3004, 1, 32'h3004, 1, 32'h5000, 1, 32'h5000, 1, 32'h5000, 0, 32'h5000, 1);
        cyc(32'h3004, 1, 32'h3004, 1, 32'h5000, 1, 32'h5000, 1, 32'h5000, 0, 32'h5000, 1);
        cyc(32'h3004, 1, 32'h3004, 0, 32'h0, 1, 32'h5000, 1, 32'h5000, 1, 32'h3008, 1);
        cyc(32'h3004, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h5000, 0, 32'h4, 1);
        // mispredict / redirect vectors
        cyc(32'h0, 1, 32'h100, 1, 32'h300, 1, 32'h200, 0, 32'h4, 1, 32'h300, 1);
        cyc(32'h0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h4, 0, 32'h104, 1);
        cyc(32'h0, 1, 32'h100, 1, 32'h300, 1, 32'h300, 0, 32'h4, 0, 32'h300, 1);
        cyc(32'h0, 0, 32'h100, 1, 32'h300, 1, 32'h200, 0, 32'h4, 0, 32'h300, 1);
        // 32-bit wrap of pc+4
        cyc(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        // reset mid-run: stats clear and the sweep restarts
        rstn = 1'b0;
        m_br = '0;
        m_mis = '0;
        cyc(32'h3004, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h3008, 0, 32'h4, 0);
        rstn = 1'b1;
        repeat (64) cyc(32'h3004, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h3008, 0, 32'h4, 0);
        cyc(32'h3004, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h3008, 0, 32'h4, 1);
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
